// File: rtl/commit_writeback_sequencer_if.sv
// Commit-in / regfile-write-out bundle for commit_writeback_sequencer.
// The master side is the ROB plus regfile; the slave side is the sequencer.
interface commit_writeback_sequencer_if #(
   parameter int REG_W  = 5,
   parameter int ROB_W  = 4,
   parameter int DATA_W = 32
);
   logic              in_commit_valid;
   logic [REG_W-1:0]  in_commit_reg;
   logic [ROB_W-1:0]  in_commit_tag;
   logic [DATA_W-1:0] in_commit_value;
   logic              out_commit_ready;
   logic              in_rollback;
   logic              in_rf_ena;
   logic [REG_W-1:0]  out_rf_reg_index;
   logic [ROB_W-1:0]  out_rf_rob_tag;
   logic [DATA_W-1:0] out_rf_value;
   logic              out_rf_rollback;
   logic              out_stall;
   logic [31:0]       out_retired_cnt;

   modport master (
      output in_commit_valid, in_commit_reg, in_commit_tag, in_commit_value,
      output in_rollback, in_rf_ena,
      input  out_commit_ready, out_rf_reg_index, out_rf_rob_tag, out_rf_value,
      input  out_rf_rollback, out_stall, out_retired_cnt
   );

   modport slave (
      input  in_commit_valid, in_commit_reg, in_commit_tag, in_commit_value,
      input  in_rollback, in_rf_ena,
      output out_commit_ready, out_rf_reg_index, out_rf_rob_tag, out_rf_value,
      output out_rf_rollback, out_stall, out_retired_cnt
   );
endinterface

// File: rtl/commit_writeback_sequencer.sv
// Buffers ROB commits and serialises them onto the single regfile write port,
// holding a rollback until older commits are written. Define COMMIT_BYPASS_EN for 0-cycle bypass.
module commit_writeback_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int REG_W      = 5,
   parameter int ROB_W      = 4,
   parameter int DATA_W     = 32
) (
   input logic clk,
   input logic rst,
   commit_writeback_sequencer_if.slave bus
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {RUN, DRAIN, ROLL} state_t;

   state_t            state, state_next;
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [CNT_W-1:0]  count, count_next;
   logic [31:0]       retired_cnt;

   logic [REG_W-1:0]  fifo_reg   [FIFO_DEPTH];
   logic [ROB_W-1:0]  fifo_tag   [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_value [FIFO_DEPTH];

   logic              ready, accept, push, pop, bypass_take, retire;
   logic [REG_W-1:0]  drive_reg;
   logic [ROB_W-1:0]  drive_tag;
   logic [DATA_W-1:0] drive_value;

   always_comb begin
      state_next  = state;
      drive_reg   = '0;
      drive_tag   = '0;
      drive_value = '0;
      bypass_take = 1'b0;

      ready  = (state == RUN) && (count < DEPTH_C);
      accept = bus.in_commit_valid && ready;

      if (state != ROLL && count != '0) begin
         drive_reg   = fifo_reg[rd_ptr];
         drive_tag   = fifo_tag[rd_ptr];
         drive_value = fifo_value[rd_ptr];
      end
`ifdef COMMIT_BYPASS_EN
      // Empty buffer in RUN: present the incoming commit straight to the regfile.
      else if (state == RUN && count == '0 && bus.in_commit_valid) begin
         drive_reg   = bus.in_commit_reg;
         drive_tag   = bus.in_commit_tag;
         drive_value = bus.in_commit_value;
         bypass_take = bus.in_rf_ena;
      end
`endif

      pop    = (count != '0) && bus.in_rf_ena;
      push   = accept && !bypass_take;
      retire = pop || bypass_take;

      count_next = count;
      if (push && !pop)
         count_next = count + CNT_W'(1);
      else if (pop && !push)
         count_next = count - CNT_W'(1);

      case (state)
         RUN:     if (bus.in_rollback) state_next = DRAIN;
         // Commits accepted before the rollback must all reach the regfile first.
         DRAIN:   if (count_next == '0) state_next = ROLL;
         ROLL:    state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         retired_cnt <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
         if (push)   wr_ptr      <= wr_ptr + PTR_W'(1);
         if (pop)    rd_ptr      <= rd_ptr + PTR_W'(1);
         if (retire) retired_cnt <= retired_cnt + 32'd1;
      end
   end

   // Buffer storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_reg[wr_ptr]   <= bus.in_commit_reg;
         fifo_tag[wr_ptr]   <= bus.in_commit_tag;
         fifo_value[wr_ptr] <= bus.in_commit_value;
      end
   end

   assign bus.out_commit_ready = ready;
   assign bus.out_rf_reg_index = drive_reg;
   assign bus.out_rf_rob_tag   = drive_tag;
   assign bus.out_rf_value     = drive_value;
   assign bus.out_rf_rollback  = (state == ROLL);
   assign bus.out_stall        = (state != RUN);
   assign bus.out_retired_cnt  = retired_cnt;
endmodule

// File: tb/tb_commit_writeback_sequencer.sv
// Directed bench for commit_writeback_sequencer (default build, no bypass).
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
module tb_commit_writeback_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   commit_writeback_sequencer_if #(.REG_W(5), .ROB_W(4), .DATA_W(32)) bus ();

   commit_writeback_sequencer #(
      .FIFO_DEPTH(4), .REG_W(5), .ROB_W(4), .DATA_W(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] r, input logic [3:0] t, input logic [31:0] d);
      bus.in_commit_valid = v;
      bus.in_commit_reg   = r;
      bus.in_commit_tag   = t;
      bus.in_commit_value = d;
   endtask

   task automatic expect_rf(input string tag, input logic [4:0] r, input logic [3:0] t, input logic [31:0] d);
      check({tag, "_reg"}, bus.out_rf_reg_index, r);
      check({tag, "_tag"}, bus.out_rf_rob_tag, t);
      check({tag, "_val"}, bus.out_rf_value, d);
   endtask

   initial begin
      drive(1'b0, '0, '0, '0);
      bus.in_rollback = 1'b0;
      bus.in_rf_ena   = 1'b0;

      // Reset state
      repeat (2) step();
      #2;
      expect_rf("rst", 0, 0, 0);
      check("rst_ready", bus.out_commit_ready, 1);
      check("rst_stall", bus.out_stall, 0);
      check("rst_rollback", bus.out_rf_rollback, 0);
      check("rst_cnt", bus.out_retired_cnt, 0);
      step();
      rst = 1'b0;

      // Single commit, 1-cycle latency
      drive(1'b1, 5'd5, 4'd3, 32'hDEADBEEF);
      bus.in_rf_ena = 1'b1;
      #2;
      check("single_ready", bus.out_commit_ready, 1);
      expect_rf("single_pre", 0, 0, 0);
      step();
      drive(1'b0, '0, '0, '0);
      #2;
      expect_rf("single", 5, 3, 32'hDEADBEEF);
      check("single_cnt0", bus.out_retired_cnt, 0);
      step();
      #2;
      expect_rf("single_post", 0, 0, 0);
      check("single_cnt1", bus.out_retired_cnt, 1);

      // Backpressure: 5 back-to-back commits with the regfile disabled
      step();
      bus.in_rf_ena = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 5'(i + 1), 4'(i), 32'h100 + 32'(i));
         #2;
         check($sformatf("bp_ready%0d", i), bus.out_commit_ready, (i < 4) ? 1 : 0);
         step();
      end
      bus.in_rf_ena = 1'b1;
      #2;
      check("bp_full_ready", bus.out_commit_ready, 0);
      expect_rf("bp_w0", 1, 0, 32'h100);
      step();
      #2;
      check("bp_ready_again", bus.out_commit_ready, 1);
      expect_rf("bp_w1", 2, 1, 32'h101);
      step();
      drive(1'b0, '0, '0, '0);
      #2;
      expect_rf("bp_w2", 3, 2, 32'h102);
      step();
      #2;
      expect_rf("bp_w3", 4, 3, 32'h103);
      step();
      #2;
      expect_rf("bp_w4", 5, 4, 32'h104);
      step();
      #2;
      expect_rf("bp_idle", 0, 0, 0);
      check("bp_cnt", bus.out_retired_cnt, 6);

      // Rollback with 3 buffered entries
      step();
      bus.in_rf_ena = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 5'(10 + i), 4'(8 + i), 32'hA0 + 32'(i));
         step();
      end
      drive(1'b0, '0, '0, '0);
      bus.in_rollback = 1'b1;
      bus.in_rf_ena   = 1'b1;
      #2;
      check("rb3_stall0", bus.out_stall, 0);
      expect_rf("rb3_w0", 10, 8, 32'hA0);
      step();
      bus.in_rollback = 1'b0;
      #2;
      check("rb3_stall1", bus.out_stall, 1);
      check("rb3_ready", bus.out_commit_ready, 0);
      check("rb3_pulse_early1", bus.out_rf_rollback, 0);
      expect_rf("rb3_w1", 11, 9, 32'hA1);
      step();
      #2;
      check("rb3_pulse_early2", bus.out_rf_rollback, 0);
      expect_rf("rb3_w2", 12, 10, 32'hA2);
      step();
      #2;
      check("rb3_pulse", bus.out_rf_rollback, 1);
      check("rb3_stall_roll", bus.out_stall, 1);
      expect_rf("rb3_roll", 0, 0, 0);
      step();
      #2;
      check("rb3_pulse_end", bus.out_rf_rollback, 0);
      check("rb3_stall_end", bus.out_stall, 0);
      check("rb3_ready_end", bus.out_commit_ready, 1);
      check("rb3_cnt", bus.out_retired_cnt, 9);

      // Rollback with empty FIFO and concurrent commit; second rollback ignored
      drive(1'b1, 5'd7, 4'd2, 32'h77);
      bus.in_rollback = 1'b1;
      #2;
      check("rbc_ready", bus.out_commit_ready, 1);
      step();
      drive(1'b0, '0, '0, '0);
      #2;
      check("rbc_stall", bus.out_stall, 1);
      check("rbc_nopulse", bus.out_rf_rollback, 0);
      expect_rf("rbc_w7", 7, 2, 32'h77);
      step();
      #2;
      check("rbc_pulse", bus.out_rf_rollback, 1);
      expect_rf("rbc_roll", 0, 0, 0);
      step();
      bus.in_rollback = 1'b0;
      #2;
      check("rbc_pulse_end", bus.out_rf_rollback, 0);
      check("rbc_stall_end", bus.out_stall, 0);
      check("rbc_cnt", bus.out_retired_cnt, 10);
      step();
      #2;
      check("rbc_single_pulse", bus.out_rf_rollback, 0);
      check("rbc_still_run", bus.out_stall, 0);

      // x0 commit: consumed and counted, index stays 0
      drive(1'b1, 5'd0, 4'd1, 32'h1234);
      step();
      drive(1'b0, '0, '0, '0);
      #2;
      expect_rf("x0", 0, 1, 32'h1234);
      step();
      #2;
      expect_rf("x0_post", 0, 0, 0);
      check("x0_cnt", bus.out_retired_cnt, 11);

      // Asynchronous reset in the middle of DRAIN
      bus.in_rf_ena = 1'b0;
      drive(1'b1, 5'd20, 4'd5, 32'h55);
      step();
      drive(1'b1, 5'd21, 4'd6, 32'h56);
      step();
      drive(1'b0, '0, '0, '0);
      bus.in_rollback = 1'b1;
      step();
      bus.in_rollback = 1'b0;
      #2;
      check("mid_stall", bus.out_stall, 1);
      expect_rf("mid_head", 20, 5, 32'h55);
      rst = 1'b1;
      #1;
      expect_rf("arst", 0, 0, 0);
      check("arst_ready", bus.out_commit_ready, 1);
      check("arst_stall", bus.out_stall, 0);
      check("arst_cnt", bus.out_retired_cnt, 0);
      step();
      rst = 1'b0;
      bus.in_rf_ena = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         #2;
         check($sformatf("arst_nopulse%0d", i), bus.out_rf_rollback, 0);
         check($sformatf("arst_idle%0d", i), bus.out_rf_reg_index, 0);
      end
      check("arst_cnt_final", bus.out_retired_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
